sync_prefetch_fifo: RTL

Single-clock first-word-fall-through (prefetch) FIFO. It is the parametrised successor to the dual-clock prefetch FIFO wrappers used in the video datapath.
- Adds occupancy level, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Sits between pixel-stream producers and consumers that share one clock domain, for example line buffering ahead of the scaler.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/sfifo_sdp_ram.sv | 34 +++
 rtl/sync_prefetch_fifo.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers and defaults for the single-clock prefetch FIFO.
// Holds width helpers and default threshold constants.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF  = 24;
    localparam int DEPTH_WIDTH_DEF = 12;
    localparam int AE_THRESH_DEF   = 4;
    localparam int AF_MARGIN_DEF   = 4;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Level must represent 0..DEPTH inclusive.
    function automatic int level_width(input int dw);
        return dw + 1;
    endfunction

    // Default almost-full point: a few entries short of capacity.
    function automatic int af_default(input int dw);
        return (1 << dw) - AF_MARGIN_DEF;
    endfunction

endpackage

// File: rtl/sfifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Ports: clk; wr_en/wr_addr/wr_data write; rd_en/rd_addr read, rd_data
// updates one edge after rd_en and holds while rd_en is low.
module sfifo_sdp_ram #(
    parameter int DATA_WIDTH  = 24,
    parameter int DEPTH_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [DEPTH_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    input  logic [DEPTH_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]  rd_data
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // No reset on the array or read register; the top tracks validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_prefetch_fifo.sv
// Single-clock first-word-fall-through FIFO with level, thresholds,
// flush and sticky overflow/underflow flags.
// Ports: clk, rst (sync, active-high), flush; wr_en/wr_data/wr_vld write
// side; rd_en/rd_vld/rd_data read side; level, almost_full,
// almost_empty, overflow, underflow status.
module sync_prefetch_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int DEPTH_WIDTH = DEPTH_WIDTH_DEF,
    parameter int AF_THRESH   = af_default(DEPTH_WIDTH),
    parameter int AE_THRESH   = AE_THRESH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_vld,
    input  logic                   rd_en,
    output logic                   rd_vld,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [DEPTH_WIDTH:0]   level,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam int PW    = clog2(DEPTH);
    localparam int LW    = level_width(DEPTH_WIDTH);

    localparam logic [LW-1:0] DEPTH_L = DEPTH[LW-1:0];
    localparam logic [LW-1:0] AF_L    = AF_THRESH[LW-1:0];
    localparam logic [LW-1:0] AE_L    = AE_THRESH[LW-1:0];
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_ONE = {{(LW-1){1'b0}}, 1'b1};

    logic [PW-1:0]         wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q,   rd_ptr_d;
    logic [LW-1:0]         level_q,    level_d;
    logic                  wr_vld_q,   wr_vld_d;
    logic                  ram_vld_q,  ram_vld_d;
    logic                  out_vld_q,  out_vld_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  af_q,       af_d;
    logic                  ae_q,       ae_d;
    logic                  ovf_q,      ovf_d;
    logic                  udf_q,      udf_d;

    logic                  push;
    logic                  pop;
    logic                  move;
    logic                  issue;
    logic                  ram_we;
    logic [LW-1:0]         unread;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    sfifo_sdp_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (issue),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // Handshake qualifiers; flush drops any same-cycle write or pop.
    always_comb begin
        push   = wr_en && wr_vld_q && !flush;
        pop    = rd_en && out_vld_q && !flush;
        ram_we = push && !rst;
    end

    // Two-stage read pipeline: RAM read register, then output register.
    // The RAM register holds its word when the output stage is busy,
    // so a read is only issued when that slot frees up this cycle.
    always_comb begin
        unread = level_q
               - {{(LW-1){1'b0}}, out_vld_q}
               - {{(LW-1){1'b0}}, ram_vld_q};
        move   = ram_vld_q && (!out_vld_q || pop);
        issue  = (unread != '0)
               && (!ram_vld_q || move)
               && !flush;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ram_vld_d  = ram_vld_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        ovf_d      = ovf_q || (wr_en && !wr_vld_q);
        udf_d      = udf_q || (rd_en && !out_vld_q);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end

        if (issue) begin
            ram_vld_d = 1'b1;
        end else if (move) begin
            ram_vld_d = 1'b0;
        end

        if (move) begin
            out_vld_d  = 1'b1;
            out_data_d = ram_rd_data;
        end else if (pop) begin
            out_vld_d  = 1'b0;
        end

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            ram_vld_d  = 1'b0;
            out_vld_d  = 1'b0;
            out_data_d = '0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end

        // Status registered from the next level so it lines up with level.
        wr_vld_d = (level_d < DEPTH_L);
        af_d     = (level_d >= AF_L);
        ae_d     = (level_d <= AE_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            wr_vld_q   <= 1'b0;
            ram_vld_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            wr_vld_q   <= wr_vld_d;
            ram_vld_q  <= ram_vld_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign wr_vld       = wr_vld_q;
    assign rd_vld       = out_vld_q;
    assign rd_data      = out_data_q;
    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
